// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_pkg
// Description : Shared state encoding and defaults for the UART TX arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_arbiter_pkg;

    localparam int ARB_DEFAULT_TIMEOUT = 1000000;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_ARM       = 2'd1,
        ARB_WAIT_DONE = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_rr_picker
// Description : Finds the first set request at or after rr_ptr, with wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter_rr_picker
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    int w_pos;

    function automatic int wrap_idx(input int a);
        return (a >= NUM_REQ) ? a - NUM_REQ : a;
    endfunction

    // Scan from the farthest offset down so the closest hit to rr_ptr wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        w_pos = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_pos = wrap_idx(int'(rr_ptr) + k);
            if (req[IDX_W'(w_pos)]) begin
                valid = 1'b1;
                index = IDX_W'(w_pos);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin sharing of one UART transmitter among requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int WORD_LENGHT    = 8,
    parameter int TIMEOUT_CYCLES = ARB_DEFAULT_TIMEOUT,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*WORD_LENGHT-1:0] data_in,
    input  logic                           Tx_ready,
    output logic                           send,
    output logic [WORD_LENGHT-1:0]         Tx_in,
    output logic [NUM_REQ-1:0]             ack,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy,
    output logic                           timeout_err
);

    localparam int               c_idx_w    = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t             r_state, w_state_nxt;
    logic                   r_rdy_meta, r_rdy_s;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic [c_idx_w-1:0]     r_rr_ptr, w_rr_ptr_nxt;
    logic [c_idx_w-1:0]     r_grant_id, w_grant_id_nxt;
    logic [c_idx_w-1:0]     w_grant_inc;
    logic                   r_send, w_send_nxt;
    logic [WORD_LENGHT-1:0] r_tx_in, w_tx_in_nxt;
    logic [NUM_REQ-1:0]     r_ack, w_ack_nxt;
    logic                   r_timeout, w_timeout_nxt;
    logic                   w_pick_valid;
    logic [c_idx_w-1:0]     w_pick_idx;
    logic [WORD_LENGHT-1:0] w_pick_word;

    uart_tx_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_idx_w)
    ) u_rr_picker (
        .req     (req),
        .rr_ptr  (r_rr_ptr),
        .valid   (w_pick_valid),
        .index   (w_pick_idx)
    );

    always_comb begin
        w_pick_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick_idx == c_idx_w'(i)) begin
                w_pick_word = data_in[i*WORD_LENGHT +: WORD_LENGHT];
            end
        end
    end

    assign w_grant_inc = (r_grant_id == c_idx_w'(NUM_REQ - 1)) ? '0
                                                                : r_grant_id + c_idx_w'(1);

    // Tx_ready comes from the baud-clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy_meta <= 1'b0;
            r_rdy_s    <= 1'b0;
        end else begin
            r_rdy_meta <= Tx_ready;
            r_rdy_s    <= r_rdy_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ARB_IDLE;
            r_cnt      <= '0;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_send     <= 1'b0;
            r_tx_in    <= '0;
            r_ack      <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_send     <= w_send_nxt;
            r_tx_in    <= w_tx_in_nxt;
            r_ack      <= w_ack_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_grant_id_nxt = r_grant_id;
        w_send_nxt     = r_send;
        w_tx_in_nxt    = r_tx_in;
        w_ack_nxt      = '0;
        w_timeout_nxt  = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                w_send_nxt = 1'b0;
                w_cnt_nxt  = '0;
                if (w_pick_valid && r_rdy_s) begin
                    w_tx_in_nxt    = w_pick_word;
                    w_grant_id_nxt = w_pick_idx;
                    w_send_nxt     = 1'b1;
                    w_state_nxt    = ARB_ARM;
                end
            end
            ARB_ARM: begin
                if (!r_rdy_s) begin
                    w_send_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ARB_WAIT_DONE;
                end else if (r_cnt == c_cnt_last) begin
                    // Advance past a requester whose word was never accepted.
                    w_timeout_nxt = 1'b1;
                    w_send_nxt    = 1'b0;
                    w_cnt_nxt     = '0;
                    w_rr_ptr_nxt  = w_grant_inc;
                    w_state_nxt   = ARB_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ARB_WAIT_DONE: begin
                w_send_nxt = 1'b0;
                if (r_rdy_s) begin
                    w_ack_nxt[r_grant_id] = 1'b1;
                    w_rr_ptr_nxt          = w_grant_inc;
                    w_state_nxt           = ARB_IDLE;
                end
            end
            default: begin
                w_send_nxt  = 1'b0;
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    assign send        = r_send;
    assign Tx_in       = r_tx_in;
    assign ack         = r_ack;
    assign grant_id    = r_grant_id;
    assign busy        = (r_state != ARB_IDLE);
    assign timeout_err = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Scoreboard bench for uart_tx_arbiter with a behavioural UART.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NR    = 4;
    localparam int WL    = 8;
    localparam int TO    = 16;
    localparam int FRAME = 20;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req;
    logic [NR*WL-1:0] data_in;
    logic            Tx_ready = 1'b1;
    logic            send;
    logic [WL-1:0]   Tx_in;
    logic [NR-1:0]   ack;
    logic [1:0]      grant_id;
    logic            busy;
    logic            timeout_err;

    uart_tx_arbiter #(
        .NUM_REQ        (NR),
        .WORD_LENGHT    (WL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .data_in     (data_in),
        .Tx_ready    (Tx_ready),
        .send        (send),
        .Tx_in       (Tx_in),
        .ack         (ack),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_to;
        int          id;
        logic [7:0]  data;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_ack(input int id, input logic [7:0] d);
        exp_t e;
        e.is_to = 1'b0; e.id = id; e.data = d;
        q.push_back(e);
    endtask

    task automatic push_to(input int id);
        exp_t e;
        e.is_to = 1'b1; e.id = id; e.data = 8'h00;
        q.push_back(e);
    endtask

    // Behavioural UART: accepts a held send after 3 cycles, then a FRAME-long frame.
    bit         stuck = 1'b0;
    bit         m_busy = 1'b0;
    int         m_wait = 0;
    int         m_cnt = 0;
    logic [7:0] acc_word = 8'h00;
    int         rise_cyc = -100;

    always @(negedge clk) begin
        if (m_busy) begin
            m_cnt++;
            if (m_cnt >= FRAME) begin
                Tx_ready = 1'b1;
                m_busy   = 1'b0;
                rise_cyc = cyc;
            end
        end else if (send && !stuck) begin
            m_wait++;
            if (m_wait >= 3) begin
                Tx_ready = 1'b0;
                m_busy   = 1'b1;
                m_cnt    = 0;
                m_wait   = 0;
                acc_word = Tx_in;
            end
        end else begin
            m_wait = 0;
        end
    end

    // Monitor: pops one expectation per ack or timeout pulse.
    int run = 0;
    int last_run = 0;
    always @(negedge clk) begin
        exp_t e;
        if (send) run++;
        else if (run != 0) begin
            last_run = run;
            run = 0;
        end
        if (!rst && ((|ack) || timeout_err)) begin
            if (q.size() == 0) begin
                chk("unexpected_event", {27'd0, timeout_err, ack}, 32'd0);
            end else begin
                e = q.pop_front();
                if (e.is_to) begin
                    chk("to_pulse",    timeout_err, 1);
                    chk("to_ack_none", ack, 0);
                    chk("to_grant_id", grant_id, e.id);
                    chk("to_send_len", last_run, TO);
                    chk("to_busy",     busy, 0);
                end else begin
                    chk("ack_onehot",  ack, 32'(1) << e.id);
                    chk("ack_no_to",   timeout_err, 0);
                    chk("ack_grant",   grant_id, e.id);
                    chk("ack_tx_in",   Tx_in, e.data);
                    chk("uart_word",   acc_word, e.data);
                    chk("ack_latency", cyc - rise_cyc, 3);
                end
            end
        end
    end

    task automatic wait_events(input int n, input bit clear_each, input bit clear_end);
        int seen = 0;
        int budget = 200 * n;
        while (seen < n && budget > 0) begin
            @(negedge clk);
            budget--;
            if ((|ack) || timeout_err) begin
                seen++;
                if (clear_each) req = req & ~ack;
            end
        end
        if (clear_end) req = '0;
        if (seen < n) chk("event_wait_expired", seen, n);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        bit saw_send;
        int budget;
        rst = 1'b1;
        req = '0;
        data_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_send",     send, 0);
        chk("rst_tx_in",    Tx_in, 0);
        chk("rst_ack",      ack, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_busy",     busy, 0);
        chk("rst_timeout",  timeout_err, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Simultaneous requests 0,1,3 held from rr_ptr=0.
        data_in = {8'h44, 8'h33, 8'h22, 8'h11};
        push_ack(0, 8'h11); push_ack(1, 8'h22); push_ack(3, 8'h44); push_ack(0, 8'h11);
        req = 4'b1011;
        wait_events(4, 1'b0, 1'b1);

        // Single request; rr_ptr=1 wraps the search to 0.
        data_in[7:0] = 8'hA5;
        push_ack(0, 8'hA5);
        req = 4'b0001;
        wait_events(1, 1'b1, 1'b1);

        // Serve 2 so rr_ptr=3, then 3 before 0.
        data_in[23:16] = 8'h5C;
        push_ack(2, 8'h5C);
        req = 4'b0100;
        wait_events(1, 1'b1, 1'b1);
        data_in[31:24] = 8'h77;
        push_ack(3, 8'h77); push_ack(0, 8'hA5);
        req = 4'b1001;
        wait_events(2, 1'b1, 1'b1);

        // Timeout on 2 (UART never accepts), then 0 is served.
        stuck = 1'b1;
        push_to(2); push_ack(0, 8'hA5);
        req = 4'b0101;
        wait_events(1, 1'b0, 1'b0);
        stuck = 1'b0;
        wait_events(1, 1'b1, 1'b1);

        // Reset during WAIT_DONE.
        data_in[15:8] = 8'h3C;
        push_ack(1, 8'h3C);
        req = 4'b0010;
        budget = 200;
        while (!(busy && !send && !Tx_ready) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("reach_wait_done", budget > 0, 1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_send",  send, 0);
        chk("midrst_ack",   ack, 0);
        chk("midrst_busy",  busy, 0);
        @(negedge clk);
        rst = 1'b0;
        saw_send = 1'b0;
        budget = 200;
        while (!Tx_ready && budget > 0) begin
            @(negedge clk);
            budget--;
            if (send) saw_send = 1'b1;
        end
        chk("midrst_frame_end", Tx_ready, 1);
        chk("midrst_no_early_grant", saw_send, 0);
        wait_events(1, 1'b1, 1'b1);

        // Requester drops req while in ARM.
        data_in[15:8] = 8'hE7;
        push_ack(1, 8'hE7);
        req = 4'b0010;
        budget = 50;
        while (!send && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("drop_reach_arm", send, 1);
        req = '0;
        wait_events(1, 1'b0, 1'b0);
        saw_send = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (send || busy) saw_send = 1'b1;
        end
        chk("drop_no_regrant", saw_send, 0);

        chk("queue_empty", q.size(), 0);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
